bus_cycle_sequencer: RTL and testbench

Parametrised machine-cycle sequencer for the i8080 core. It generalises the fixed T1/T2/TW/T3 state walk into full bus cycles of configurable length, with address/data width parameters, read/write strobes, a wait-state timeout, and HOLD/HLDA bus release. It sits between the core's instruction/control logic, which issues one request per machine cycle, and the external pins.

---
 rtl/bus_cycle_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer
// -------------------
// Machine-cycle sequencer for an i8080-style core. It takes one request per
// machine cycle from the core's control logic and walks it through
// T1, T2, optional TW wait states, T3 and optional T4/T5. It drives the bus
// strobes and enables, captures read data, aborts a cycle whose wait states
// run too long, and gives the bus away on a HOLD request.
//
// Ports
//   clk, rst        : clock (rising edge) and asynchronous active-high reset
//   start           : level request for a new machine cycle
//   cycle_len       : requested T-state count (clamped to 3..5)
//   is_read/is_write: cycle direction (a read wins if both are set)
//   addr_in, wdata, status_in : cycle address, write data, T1 status word
//   ready           : external ready, sampled in T2/TW
//   hold            : bus hold request, honoured only at an acceptance point
//   data_in         : external data bus, captured when leaving T3 of a read
//   busy, t_state   : activity flag and state code (T1=0 .. HOLD=6 IDLE=7)
//   sync, dbin, write_n, wwait, hlda : bus control pins
//   addr_out/addr_oe, data_out/data_oe : bus drive values and enables
//   rdata/rdata_valid : captured read data and its one-cycle strobe
//   done            : high in the last T-state of a completed cycle
//   timeout         : one-cycle pulse after a wait-state abort
module bus_cycle_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            cycle_len,
    input  logic                  is_read,
    input  logic                  is_write,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] status_in,
    input  logic                  ready,
    input  logic                  hold,
    output logic                  busy,
    output logic [2:0]            t_state,
    output logic                  sync,
    output logic                  dbin,
    output logic                  write_n,
    output logic                  wwait,
    output logic                  hlda,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  addr_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_oe,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  rdata_valid,
    output logic                  done,
    output logic                  timeout
);

    // State codes double as the externally visible t_state value.
    localparam logic [2:0] S_T1   = 3'd0;
    localparam logic [2:0] S_T2   = 3'd1;
    localparam logic [2:0] S_TW   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_T4   = 3'd4;
    localparam logic [2:0] S_T5   = 3'd5;
    localparam logic [2:0] S_HOLD = 3'd6;
    localparam logic [2:0] S_IDLE = 3'd7;

    // The wait counter only has to reach MAX_WAIT; in unlimited mode it just
    // saturates and is never compared.
    localparam int             WCW        = (MAX_WAIT < 255) ? 8 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [2:0]            len_q, len_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  timeout_q, timeout_d;

    logic                  last_t;
    logic                  accept;
    logic [2:0]            len_clamp;
    logic                  mid_phase;

    // Last T-state of the current cycle, where the next request is taken.
    assign last_t = ((state_q == S_T3) && (len_q == 3'd3)) ||
                    ((state_q == S_T4) && (len_q == 3'd4)) ||
                    (state_q == S_T5);

    always_comb begin
        len_clamp = cycle_len;
        if (cycle_len < 3'd3) begin
            len_clamp = 3'd3;
        end else if (cycle_len > 3'd5) begin
            len_clamp = 3'd5;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        status_d      = status_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        len_d         = len_q;
        wait_cnt_d    = wait_cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        timeout_d     = 1'b0;
        accept        = 1'b0;

        case (state_q)
            S_IDLE: accept = 1'b1;
            S_T1:   state_d = S_T2;
            S_T2: begin
                if (ready) begin
                    state_d = S_T3;
                end else begin
                    state_d    = S_TW;
                    wait_cnt_d = WCW'(1);
                end
            end
            S_TW: begin
                if (ready) begin
                    state_d = S_T3;
                end else if ((MAX_WAIT > 0) && (wait_cnt_q == WAIT_LIMIT)) begin
                    // Abort: straight to IDLE, no done and no read capture.
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else if (wait_cnt_q != {WCW{1'b1}}) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_T3: begin
                // Read data is taken on the edge leaving T3, whatever follows.
                if (rd_q) begin
                    rdata_d       = data_in;
                    rdata_valid_d = 1'b1;
                end
                if (last_t) begin
                    accept = 1'b1;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4: begin
                if (last_t) begin
                    accept = 1'b1;
                end else begin
                    state_d = S_T5;
                end
            end
            S_T5:   accept = 1'b1;
            S_HOLD: begin
                if (!hold) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Hold has priority over a pending start; the requester keeps start
        // asserted and is served after the bus comes back.
        if (accept) begin
            if (hold) begin
                state_d = S_HOLD;
            end else if (start) begin
                state_d    = S_T1;
                addr_d     = addr_in;
                wdata_d    = wdata;
                status_d   = status_in;
                rd_d       = is_read;
                wr_d       = is_write && !is_read;
                len_d      = len_clamp;
                wait_cnt_d = '0;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            status_q      <= '0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            len_q         <= 3'd3;
            wait_cnt_q    <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            status_q      <= status_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            len_q         <= len_d;
            wait_cnt_q    <= wait_cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    // T2, TW and T3: the data phase where strobes and write data are active.
    assign mid_phase = (state_q == S_T2) || (state_q == S_TW) || (state_q == S_T3);

    assign busy        = (state_q != S_IDLE);
    assign t_state     = state_q;
    assign sync        = (state_q == S_T1);
    assign wwait       = (state_q == S_TW);
    assign hlda        = (state_q == S_HOLD);
    assign dbin        = rd_q && mid_phase;
    assign write_n     = !(wr_q && ((state_q == S_TW) || (state_q == S_T3)));
    assign addr_out    = addr_q;
    assign addr_oe     = (state_q != S_IDLE) && (state_q != S_HOLD);
    assign data_oe     = sync || (wr_q && mid_phase);
    assign data_out    = sync ? status_q : ((wr_q && mid_phase) ? wdata_q : '0);
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = last_t;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Testbench for bus_cycle_sequencer: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// cycle-position model of the bus protocol.
module tb_bus_cycle_sequencer;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    cycle_len;
    logic          is_read, is_write;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] wdata, status_in, data_in;
    logic          ready, hold;
    logic          busy, sync, dbin, write_n, wwait, hlda, addr_oe, data_oe;
    logic          rdata_valid, done, timeout;
    logic [2:0]    t_state;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out, rdata;

    int checks = 0;
    int errors = 0;

    bus_cycle_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .start(start), .cycle_len(cycle_len),
        .is_read(is_read), .is_write(is_write), .addr_in(addr_in),
        .wdata(wdata), .status_in(status_in), .ready(ready), .hold(hold),
        .busy(busy), .t_state(t_state), .sync(sync), .dbin(dbin),
        .write_n(write_n), .wwait(wwait), .hlda(hlda), .addr_out(addr_out),
        .addr_oe(addr_oe), .data_out(data_out), .data_oe(data_oe),
        .rdata(rdata), .data_in(data_in), .rdata_valid(rdata_valid),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 hold, 2 inside a cycle. Inside a cycle, m_pos
    // counts the numbered T-states (1=T1 .. 5=T5) and m_waiting marks TW.
    int            m_phase, m_pos, m_len, m_waits;
    bit            m_waiting, m_rd, m_wr, m_rv, m_to;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_status, m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_len = 3; m_waits = 0;
        m_waiting = 0; m_rd = 0; m_wr = 0; m_rv = 0; m_to = 0;
        m_addr = '0; m_wdata = '0; m_status = '0; m_rdata = '0;
    endtask

    task automatic model_edge();
        bit acc;
        acc  = (m_phase == 0) || (m_phase == 2 && !m_waiting && m_pos == m_len);
        m_rv = 0;
        m_to = 0;
        if (m_phase == 2 && !m_waiting && m_pos == 3 && m_rd) begin
            m_rdata = data_in;
            m_rv    = 1;
        end
        if (acc) begin
            if (hold) m_phase = 1;
            else if (start) begin
                m_phase = 2; m_pos = 1; m_waiting = 0;
                m_len    = (cycle_len < 3) ? 3 : ((cycle_len > 5) ? 5 : int'(cycle_len));
                m_rd     = is_read;
                m_wr     = is_write && !is_read;
                m_addr   = addr_in;
                m_wdata  = wdata;
                m_status = status_in;
            end else m_phase = 0;
        end else if (m_phase == 1) begin
            if (!hold) m_phase = 0;
        end else if (m_waiting) begin
            if (ready) begin
                m_waiting = 0; m_pos = 3;
            end else if (m_waits == MW) begin
                m_phase = 0; m_waiting = 0; m_to = 1;
            end else m_waits++;
        end else if (m_pos == 2) begin
            if (ready) m_pos = 3;
            else begin
                m_waiting = 1; m_waits = 1;
            end
        end else m_pos++;
    endtask

    task automatic compare();
        int e_t;
        bit cyc, mid, e_sync, e_wr_active;
        cyc    = (m_phase == 2);
        mid    = cyc && (m_waiting || m_pos == 2 || m_pos == 3);
        e_sync = cyc && !m_waiting && m_pos == 1;
        e_wr_active = m_wr && cyc && (m_waiting || m_pos == 3);
        if (m_phase == 0) e_t = 7;
        else if (m_phase == 1) e_t = 6;
        else if (m_waiting) e_t = 2;
        else e_t = (m_pos == 1) ? 0 : ((m_pos == 2) ? 1 : m_pos);
        chk("t_state", 32'(t_state), 32'(e_t));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("sync", 32'(sync), 32'(e_sync));
        chk("dbin", 32'(dbin), 32'(m_rd && mid));
        chk("write_n", 32'(write_n), 32'(!e_wr_active));
        chk("wwait", 32'(wwait), 32'(cyc && m_waiting));
        chk("hlda", 32'(hlda), 32'(m_phase == 1));
        chk("addr_oe", 32'(addr_oe), 32'(cyc));
        chk("addr_out", 32'(addr_out), 32'(m_addr));
        chk("data_oe", 32'(data_oe), 32'(e_sync || (m_wr && mid)));
        chk("data_out", 32'(data_out),
            32'(e_sync ? m_status : ((m_wr && mid) ? m_wdata : 8'h00)));
        chk("rdata", 32'(rdata), 32'(m_rdata));
        chk("rdata_valid", 32'(rdata_valid), 32'(m_rv));
        chk("done", 32'(done), 32'(cyc && !m_waiting && m_pos == m_len));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic step_t(input int exp_t);
        step();
        chk("t_literal", 32'(t_state), 32'(exp_t));
    endtask

    task automatic set_req(input bit s, input logic [2:0] l, input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
        start = s; cycle_len = l; is_read = r; is_write = w; addr_in = a; wdata = wd;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_write_n", 32'(write_n), 32'd1);
        chk("rst_wwait", 32'(wwait), 32'd0);
        chk("rst_addr_oe", 32'(addr_oe), 32'd0);
        chk("rst_t_state", 32'(t_state), 32'd7);
        model_reset();
        compare();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_req(0, 3'd3, 0, 0, '0, '0);
        status_in = 8'h00; data_in = 8'h00; ready = 1'b1; hold = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_write_n", 32'(write_n), 32'd1);
        chk("reset_t_state", 32'(t_state), 32'd7);
        rst = 1'b0;

        // Read, length 3, no waits.
        set_req(1, 3'd3, 1, 0, 16'h1234, 8'h00);
        status_in = 8'hA2; data_in = 8'hA5; ready = 1'b1;
        step_t(0);
        chk("rd_sync", 32'(sync), 32'd1);
        chk("rd_status", 32'(data_out), 32'hA2);
        start = 1'b0;
        step_t(1);
        chk("rd_dbin", 32'(dbin), 32'd1);
        chk("rd_addr", 32'(addr_out), 32'h1234);
        step_t(3);
        chk("rd_done", 32'(done), 32'd1);
        step_t(7);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        chk("rd_valid", 32'(rdata_valid), 32'd1);

        // Write, length 4, two wait states.
        set_req(1, 3'd4, 0, 1, 16'h4000, 8'h3C);
        step_t(0);
        start = 1'b0; ready = 1'b0;
        step_t(1);
        chk("wr_data_t2", 32'(data_out), 32'h3C);
        step_t(2);
        chk("wr_wwait", 32'(wwait), 32'd1);
        chk("wr_write_n_tw", 32'(write_n), 32'd0);
        step_t(2);
        ready = 1'b1;
        step_t(3);
        chk("wr_write_n_t3", 32'(write_n), 32'd0);
        chk("wr_data_t3", 32'(data_out), 32'h3C);
        step_t(4);
        chk("wr_done", 32'(done), 32'd1);
        step_t(7);

        // Read that times out after MW wait states.
        set_req(1, 3'd3, 1, 0, 16'h0055, 8'h00);
        data_in = 8'h11;
        step_t(0);
        start = 1'b0; ready = 1'b0;
        step_t(1);
        step_t(2);
        step_t(2);
        step_t(2);
        step_t(7);
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_rdata_kept", 32'(rdata), 32'hA5);
        chk("to_no_valid", 32'(rdata_valid), 32'd0);
        ready = 1'b1;
        step_t(7);
        chk("to_pulse_end", 32'(timeout), 32'd0);

        // Length 5 with start held, hold raised in T3.
        set_req(1, 3'd5, 0, 0, 16'hBEEF, 8'h00);
        step_t(0);
        step_t(1);
        step_t(3);
        hold = 1'b1;
        step_t(4);
        step_t(5);
        step_t(6);
        chk("hold_hlda", 32'(hlda), 32'd1);
        chk("hold_addr_oe", 32'(addr_oe), 32'd0);
        step_t(6);
        hold = 1'b0;
        step_t(7);
        step_t(0);
        start = 1'b0;
        step_t(1); step_t(3); step_t(4); step_t(5); step_t(7);

        // Clamp: length 0 then back-to-back length 7.
        set_req(1, 3'd0, 0, 0, 16'h0100, 8'h00);
        step_t(0);
        cycle_len = 3'd7;
        step_t(1);
        step_t(3);
        chk("clamp3_done", 32'(done), 32'd1);
        step_t(0);
        start = 1'b0;
        step_t(1); step_t(3); step_t(4); step_t(5);
        chk("clamp5_done", 32'(done), 32'd1);
        step_t(7);

        // Asynchronous reset in TW of a write.
        set_req(1, 3'd3, 0, 1, 16'h0F0F, 8'h77);
        step_t(0);
        start = 1'b0; ready = 1'b0;
        step_t(1);
        step_t(2);
        async_reset();
        ready = 1'b1;
        step_t(7);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 3) != 0);
            cycle_len = 3'($urandom_range(0, 7));
            is_read   = 1'($urandom_range(0, 1));
            is_write  = 1'($urandom_range(0, 1));
            addr_in   = 16'($urandom);
            wdata     = 8'($urandom);
            status_in = 8'($urandom);
            data_in   = 8'($urandom);
            ready     = ($urandom_range(0, 3) != 0);
            hold      = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) async_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
